trace_buffer: RTL and testbench
===============================

Name: trace_buffer

Overview:
- Synthesizable retirement-trace unit for the single-cycle MIPS subset core. It replaces per-cycle $display tracing with a hardware buffer.
- Each cycle it captures the retired instruction record: sequence number, pc, instruction, regfile write address and data-memory address.
- Records go into a parametrised FIFO that is drained through a valid/ready port.
- It detects a halt (jump-to-self) and reports overflow and drops. Sits beside the cpu; the testbench or a debug UART consumes the read port.

Parameters:
- XLEN, 32, width of pc, instruction and data-memory address.
- RADDR_W, 5, register-file address width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- SEQ_W, 17, sequence-counter width; wraps modulo 2^SEQ_W.
- HALT_CYCLES, 2, consecutive retires with unchanged pc that declare a halt; at least 1.
- OVERWRITE, 0, full policy: 0 = drop newest, 1 = overwrite oldest.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  capture enable.
- retire  in  1  an instruction retires this cycle; tie to 1 for the single-cycle core.
- pc  in  XLEN  pc of the retiring instruction.
- instr  in  32  retiring instruction word.
- regWE  in  1  regfile write enable.
- regWAddr  in  RADDR_W  regfile write address.
- dmWE  in  1  data-memory write enable.
- dmAddr  in  XLEN  data-memory address.
- rd_ready  in  1  consumer accepts the head record.
- rd_valid  out  1  head record valid (FIFO non-empty).
- rd_seq  out  SEQ_W  head sequence number.
- rd_pc  out  XLEN  head pc.
- rd_instr  out  32  head instruction.
- rd_regWAddr  out  RADDR_W  head regfile write address; 0 if regWE was 0.
- rd_dmAddr  out  XLEN  head data-memory address.
- rd_dmWE  out  1  head data-memory write flag.
- level  out  clog2(DEPTH)+1  entries currently held.
- halted  out  1  halt detected.
- overflow  out  1  sticky; set when any record is lost.
- drop_cnt  out  DROP_W  lost records, saturating.

Behaviour:
- Reset (asynchronous):
  - state IDLE, FIFO empty.
  - All outputs 0: rd_valid=0, level=0, halted=0, overflow=0, drop_cnt=0.
  - Sequence counter 0, pc-repeat counter 0.
- States: IDLE, CAPTURE, HALTED. State is registered, so each decision takes effect the following cycle.
  - IDLE -> CAPTURE when enable=1. The first capture happens in the cycle after enable is seen.
  - CAPTURE -> IDLE when enable=0. The retire in that same cycle is still captured.
  - CAPTURE -> HALTED when the repeat counter reaches HALT_CYCLES.
  - HALTED -> IDLE when enable=0. halted stays 1 until reset.
- Capture, in CAPTURE state with retire=1, each cycle:
  - Push record {seq, pc, instr, regWE ? regWAddr : 0, dmAddr, dmWE}.
  - seq increments whether or not the push succeeds; it wraps from 2^SEQ_W-1 to 0.
  - Nothing is captured in IDLE or HALTED.
- Halt detection:
  - A register holds the pc of the previous retire. Its valid bit clears on reset and on entry to CAPTURE.
  - On a retire whose pc equals the held pc, the repeat counter increments; on a differing pc it resets to 0.
  - Example, HALT_CYCLES=2: the retire sequence pc A, A, A pushes all three records, then enters HALTED.
- Read side:
  - First-word-fall-through: rd_* show the head entry combinationally from storage.
  - Pop happens when rd_valid && rd_ready.
  - rd_* values are don't-care while rd_valid=0.
- Simultaneous push and pop:
  - Not full: both occur; level is unchanged.
  - Full: the pop frees the slot, so the push is accepted and no drop is counted, in either mode.
- Full, push, no pop:
  - OVERWRITE=0: new record discarded.
  - OVERWRITE=1: oldest entry discarded; read and write pointers both advance; level stays DEPTH.
  - In both cases overflow is set and drop_cnt increments, holding at 2^DROP_W-1.
- Pointers: clog2(DEPTH)-bit wrap-around with a separate level counter. The level counter distinguishes full from empty.
- Reset mid-operation discards all buffered records immediately, with no pops.

Decomposition:
- Shared package trace_pkg:
  - state encoding localparams.
  - record field widths and bit offsets of the packed record (total width SEQ_W + 2·XLEN + 32 + RADDR_W + 1).
- One sub-module: trace_fifo.
  - Parametrised storage with level counter, FWFT output and an overwrite mode.
  - Used by trace_buffer around the capture FSM.

Test Plan:
- Reset, then enable=1 and retire pcs 0,4,8 -> rd_valid rises 2 cycles after enable. Records come out as seq 0,1,2 with pc 0,4,8; level drops to 0 after 3 pops.
- DEPTH=4, OVERWRITE=0, rd_ready=0, 6 retires pc 0..20 -> level=4; head pc 0 (seq 0); overflow=1, drop_cnt=2.
- Same with OVERWRITE=1 -> level=4; draining yields seq 2,3,4,5 (pc 8..20); drop_cnt=2.
- HALT_CYCLES=2, pc stream 0x10, 0x14, 0x14, 0x14, 0x18 -> 4 records pushed, last pc 0x14; halted=1 from the cycle after the third 0x14; pc 0x18 not captured.
- Full FIFO with rd_ready=1 and a retire in the same cycle -> push accepted; level stays 4; drop_cnt unchanged.
- Assert reset mid-capture with level=3 -> the same cycle shows rd_valid=0, level=0, halted=0; after release and re-enable, seq restarts at 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the retirement-trace unit: FSM states and the
// bit layout of a packed trace record (LSB first: dmWE, dmAddr, regWAddr, instr, pc, seq).
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    localparam int unsigned INSTR_W = 32;

    function automatic int unsigned rec_width(input int unsigned xlen,
                                              input int unsigned raddr_w,
                                              input int unsigned seq_w);
        return seq_w + 2 * xlen + INSTR_W + raddr_w + 1;
    endfunction

    function automatic int unsigned off_dmwe();
        return 0;
    endfunction

    function automatic int unsigned off_dmaddr();
        return 1;
    endfunction

    function automatic int unsigned off_raddr(input int unsigned xlen);
        return 1 + xlen;
    endfunction

    function automatic int unsigned off_instr(input int unsigned xlen,
                                              input int unsigned raddr_w);
        return 1 + xlen + raddr_w;
    endfunction

    function automatic int unsigned off_pc(input int unsigned xlen,
                                           input int unsigned raddr_w);
        return 1 + xlen + raddr_w + INSTR_W;
    endfunction

    function automatic int unsigned off_seq(input int unsigned xlen,
                                            input int unsigned raddr_w);
        return 1 + 2 * xlen + raddr_w + INSTR_W;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through record FIFO with level counter; when full it either
// drops the incoming record or evicts the oldest one (OVERWRITE != 0).
module trace_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned OVERWRITE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop_req,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     dropped
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             evict;

    always_comb begin
        full    = (level == LVL_W'(DEPTH));
        valid   = (level != '0);
        pop     = valid && pop_req;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        wr_en   = push && (!full || pop || (OVERWRITE != 0));
        evict   = push && full && !pop && (OVERWRITE != 0);
        dropped = push && full && !pop;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop || evict)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en && !evict, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/trace_buffer.sv
// Retirement-trace unit: captures one record per retired instruction into a
// FWFT FIFO, detects jump-to-self halts and counts lost records.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RADDR_W     = 5,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SEQ_W       = 17,
    parameter int unsigned HALT_CYCLES = 2,
    parameter int unsigned OVERWRITE   = 0,
    parameter int unsigned DROP_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   retire,
    input  logic [XLEN-1:0]        pc,
    input  logic [31:0]            instr,
    input  logic                   regWE,
    input  logic [RADDR_W-1:0]     regWAddr,
    input  logic                   dmWE,
    input  logic [XLEN-1:0]        dmAddr,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [SEQ_W-1:0]       rd_seq,
    output logic [XLEN-1:0]        rd_pc,
    output logic [31:0]            rd_instr,
    output logic [RADDR_W-1:0]     rd_regWAddr,
    output logic [XLEN-1:0]        rd_dmAddr,
    output logic                   rd_dmWE,
    output logic [$clog2(DEPTH):0] level,
    output logic                   halted,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int unsigned REC_W      = rec_width(XLEN, RADDR_W, SEQ_W);
    localparam int unsigned OFF_DMWE   = off_dmwe();
    localparam int unsigned OFF_DMADDR = off_dmaddr();
    localparam int unsigned OFF_RADDR  = off_raddr(XLEN);
    localparam int unsigned OFF_INSTR  = off_instr(XLEN, RADDR_W);
    localparam int unsigned OFF_PC     = off_pc(XLEN, RADDR_W);
    localparam int unsigned OFF_SEQ    = off_seq(XLEN, RADDR_W);
    localparam int unsigned REP_W      = $clog2(HALT_CYCLES + 1);

    state_t             state;
    state_t             state_next;
    logic               capture;
    logic               entering;
    logic               halt_hit;
    logic [XLEN-1:0]    prev_pc;
    logic               prev_valid;
    logic [REP_W-1:0]   rep_cnt;
    logic [REP_W-1:0]   rep_next;
    logic [SEQ_W-1:0]   seq;
    logic [RADDR_W-1:0] waddr_masked;
    logic [REC_W-1:0]   rec_in;
    logic [REC_W-1:0]   rec_out;
    logic               dropped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // halt is judged on the counter value this retire produces, so the
    // repeating retire is still captured and nothing after it is
    always_comb begin
        rep_next = (prev_valid && (pc == prev_pc)) ? rep_cnt + 1'b1 : '0;
        halt_hit = capture && (rep_next == REP_W'(HALT_CYCLES));
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (enable) state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                if (halt_hit)
                    state_next = ST_HALTED;
                else if (!enable)
                    state_next = ST_IDLE;
            end
            ST_HALTED:  if (!enable) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        capture  = (state == ST_CAPTURE) && retire;
        entering = (state != ST_CAPTURE) && (state_next == ST_CAPTURE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            rep_cnt    <= '0;
            seq        <= '0;
            halted     <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (entering) begin
                prev_valid <= 1'b0;
            end else if (capture) begin
                prev_pc    <= pc;
                prev_valid <= 1'b1;
                rep_cnt    <= rep_next;
            end
            if (capture)
                seq <= seq + 1'b1;
            if (halt_hit)
                halted <= 1'b1;
            if (dropped) begin
                overflow <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        waddr_masked = regWE ? regWAddr : '0;
        rec_in       = {seq, pc, instr, waddr_masked, dmAddr, dmWE};
    end

    trace_fifo #(
        .WIDTH     (REC_W),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (capture),
        .wdata   (rec_in),
        .pop_req (rd_ready),
        .head    (rec_out),
        .valid   (rd_valid),
        .level   (level),
        .dropped (dropped)
    );

    always_comb begin
        rd_dmWE     = rec_out[OFF_DMWE];
        rd_dmAddr   = rec_out[OFF_DMADDR +: XLEN];
        rd_regWAddr = rec_out[OFF_RADDR +: RADDR_W];
        rd_instr    = rec_out[OFF_INSTR +: INSTR_W];
        rd_pc       = rec_out[OFF_PC +: XLEN];
        rd_seq      = rec_out[OFF_SEQ +: SEQ_W];
    end

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: two DEPTH=4 instances (drop-newest and overwrite-oldest
// with narrow seq/drop counters) driven in lockstep against a queue-based model.
module tb_trace_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HALT  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        retire;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        regWE;
    logic [4:0]  regWAddr;
    logic        dmWE;
    logic [31:0] dmAddr;
    logic        rd_ready;

    logic        va, vb, dwa, dwb, halta, haltb, ovfa, ovfb;
    logic [16:0] seqa;
    logic [3:0]  seqb;
    logic [31:0] pca, pcb, insa, insb, dmaa, dmab;
    logic [4:0]  raa, rab;
    logic [2:0]  lvla, lvlb;
    logic [7:0]  dropa;
    logic [1:0]  dropb;

    logic [31:0] o_seq [2];
    logic [31:0] o_pc [2];
    logic [31:0] o_instr [2];
    logic [31:0] o_dma [2];
    logic [31:0] o_lvl [2];
    logic [31:0] o_drop [2];
    logic [4:0]  o_ra [2];
    logic        o_valid [2];
    logic        o_dwe [2];
    logic        o_halt [2];
    logic        o_ovf [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trace_buffer #(.DEPTH(DEPTH), .OVERWRITE(0), .HALT_CYCLES(HALT)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .retire(retire), .pc(pc),
        .instr(instr), .regWE(regWE), .regWAddr(regWAddr), .dmWE(dmWE),
        .dmAddr(dmAddr), .rd_ready(rd_ready), .rd_valid(va), .rd_seq(seqa),
        .rd_pc(pca), .rd_instr(insa), .rd_regWAddr(raa), .rd_dmAddr(dmaa),
        .rd_dmWE(dwa), .level(lvla), .halted(halta), .overflow(ovfa),
        .drop_cnt(dropa)
    );

    trace_buffer #(.DEPTH(DEPTH), .OVERWRITE(1), .HALT_CYCLES(HALT),
                   .SEQ_W(4), .DROP_W(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .retire(retire), .pc(pc),
        .instr(instr), .regWE(regWE), .regWAddr(regWAddr), .dmWE(dmWE),
        .dmAddr(dmAddr), .rd_ready(rd_ready), .rd_valid(vb), .rd_seq(seqb),
        .rd_pc(pcb), .rd_instr(insb), .rd_regWAddr(rab), .rd_dmAddr(dmab),
        .rd_dmWE(dwb), .level(lvlb), .halted(haltb), .overflow(ovfb),
        .drop_cnt(dropb)
    );

    assign o_seq[0] = 32'(seqa);   assign o_seq[1] = 32'(seqb);
    assign o_pc[0] = pca;          assign o_pc[1] = pcb;
    assign o_instr[0] = insa;      assign o_instr[1] = insb;
    assign o_dma[0] = dmaa;        assign o_dma[1] = dmab;
    assign o_lvl[0] = 32'(lvla);   assign o_lvl[1] = 32'(lvlb);
    assign o_drop[0] = 32'(dropa); assign o_drop[1] = 32'(dropb);
    assign o_ra[0] = raa;          assign o_ra[1] = rab;
    assign o_valid[0] = va;        assign o_valid[1] = vb;
    assign o_dwe[0] = dwa;         assign o_dwe[1] = dwb;
    assign o_halt[0] = halta;      assign o_halt[1] = haltb;
    assign o_ovf[0] = ovfa;        assign o_ovf[1] = ovfb;

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] dma;
        logic [4:0]  ra;
        logic        dwe;
    } rec_t;

    rec_t        q0[$];
    rec_t        q1[$];
    int          mmode [2];     // 0 idle, 1 capturing, 2 halted
    int unsigned mseq [2];
    int unsigned mdrop [2];
    bit          movf [2];
    bit          mhalt [2];
    int unsigned mrun [2];      // length of the current run of identical captured pcs
    logic [31:0] mlast [2];

    function automatic int unsigned seq_mod(input int d);
        return (d == 0) ? 32'd131072 : 32'd16;
    endfunction

    function automatic int unsigned drop_max(input int d);
        return (d == 0) ? 32'd255 : 32'd3;
    endfunction

    function automatic int unsigned qsize(input int d);
        if (d == 0) return q0.size();
        return q1.size();
    endfunction

    function automatic rec_t qhead(input int d);
        if (d == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic qpush(input int d, input rec_t r);
        if (d == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    task automatic qpop(input int d);
        rec_t r;
        if (d == 0) r = q0.pop_front(); else r = q1.pop_front();
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            mmode[d] = 0; mseq[d] = 0; mdrop[d] = 0;
            movf[d] = 0; mhalt[d] = 0; mrun[d] = 0; mlast[d] = '0;
        end
    endtask

    task automatic model_tick();
        bit   pop;
        bit   cap;
        bit   hit;
        rec_t r;
        if (reset) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            pop = (qsize(d) > 0) && rd_ready;
            cap = (mmode[d] == 1) && retire;
            hit = 0;
            if (pop) qpop(d);
            if (cap) begin
                r.seq = mseq[d]; r.pc = pc; r.instr = instr; r.dma = dmAddr;
                r.ra = regWE ? regWAddr : 5'd0; r.dwe = dmWE;
                mseq[d] = (mseq[d] + 1) % seq_mod(d);
                if (qsize(d) < DEPTH) begin
                    qpush(d, r);
                end else begin
                    if (d == 1) begin
                        qpop(d);
                        qpush(d, r);
                    end
                    movf[d] = 1;
                    if (mdrop[d] < drop_max(d)) mdrop[d]++;
                end
                if (mrun[d] > 0 && pc == mlast[d]) mrun[d]++; else mrun[d] = 1;
                mlast[d] = pc;
                hit = (mrun[d] == HALT + 1);
            end
            case (mmode[d])
                0: if (enable) begin mmode[d] = 1; mrun[d] = 0; end
                1: if (hit) begin mmode[d] = 2; mhalt[d] = 1; end
                   else if (!enable) mmode[d] = 0;
                default: if (!enable) mmode[d] = 0;
            endcase
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic drive_retire(input logic [31:0] p);
        retire   = 1'b1;
        pc       = p;
        instr    = $urandom;
        regWE    = 1'($urandom);
        regWAddr = 5'($urandom);
        dmWE     = 1'($urandom);
        dmAddr   = $urandom;
    endtask

    task automatic reset_dut();
        reset = 1'b1; enable = 1'b0; retire = 1'b0; rd_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; retire = 1'b0; rd_ready = 1'b0;
        pc = '0; instr = '0; regWE = 0; regWAddr = '0; dmWE = 0; dmAddr = '0;
        model_reset();
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (o_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid dut%0d: got %0h, expected 0", d, o_valid[d]); end
            n_checks++; if (o_lvl[d] !== 32'd0) begin n_fail++; $display("FAIL reset_level dut%0d: got %0h, expected 0", d, o_lvl[d]); end
            n_checks++; if (o_halt[d] !== 1'b0) begin n_fail++; $display("FAIL reset_halted dut%0d: got %0h, expected 0", d, o_halt[d]); end
            n_checks++; if (o_ovf[d] !== 1'b0) begin n_fail++; $display("FAIL reset_overflow dut%0d: got %0h, expected 0", d, o_ovf[d]); end
            n_checks++; if (o_drop[d] !== 32'd0) begin n_fail++; $display("FAIL reset_drop dut%0d: got %0h, expected 0", d, o_drop[d]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        enable = 1'b1;
        drive_retire(32'h100);      // seen in IDLE, never captured
        tick();
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (o_valid[d] !== 1'b0) begin n_fail++; $display("FAIL basic_latency dut%0d: got %0h, expected 0", d, o_valid[d]); end
        end
        drive_retire(32'd0); tick();
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (o_valid[d] !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid dut%0d: got %0h, expected 1", d, o_valid[d]); end
        end
        drive_retire(32'd4); tick();
        drive_retire(32'd8); enable = 1'b0; tick();
        retire = 1'b0;
        tick();
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 2; d++) begin
                n_checks++; if (o_seq[d] !== 32'(k)) begin n_fail++; $display("FAIL basic_seq dut%0d: got %0h, expected %0h", d, o_seq[d], k); end
                n_checks++; if (o_pc[d] !== 32'(4 * k)) begin n_fail++; $display("FAIL basic_pc dut%0d: got %0h, expected %0h", d, o_pc[d], 4 * k); end
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (o_lvl[d] !== 32'd0) begin n_fail++; $display("FAIL basic_drained dut%0d: got %0h, expected 0", d, o_lvl[d]); end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int first;
        reset_dut();
        enable = 1'b1; retire = 1'b0; tick();
        for (int i = 0; i < 6; i++) begin
            drive_retire(32'(4 * i));
            if (i == 5) enable = 1'b0;
            tick();
        end
        retire = 1'b0;
        for (int d = 0; d < 2; d++) begin
            first = (d == 0) ? 0 : 2;
            n_checks++; if (o_lvl[d] !== 32'd4) begin n_fail++; $display("FAIL ovf_level dut%0d: got %0h, expected 4", d, o_lvl[d]); end
            n_checks++; if (o_ovf[d] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag dut%0d: got %0h, expected 1", d, o_ovf[d]); end
            n_checks++; if (o_drop[d] !== 32'd2) begin n_fail++; $display("FAIL ovf_drop dut%0d: got %0h, expected 2", d, o_drop[d]); end
            n_checks++; if (o_seq[d] !== 32'(first)) begin n_fail++; $display("FAIL ovf_head_seq dut%0d: got %0h, expected %0h", d, o_seq[d], first); end
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 2; d++) begin
                first = (d == 0) ? 0 : 2;
                n_checks++; if (o_seq[d] !== 32'(k + first)) begin n_fail++; $display("FAIL ovf_drain_seq dut%0d: got %0h, expected %0h", d, o_seq[d], k + first); end
                n_checks++; if (o_pc[d] !== 32'(4 * (k + first))) begin n_fail++; $display("FAIL ovf_drain_pc dut%0d: got %0h, expected %0h", d, o_pc[d], 4 * (k + first)); end
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_full_pop_push();
        reset_dut();
        enable = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            drive_retire(32'h40 + 32'(4 * i)); tick();
        end
        drive_retire(32'h50); rd_ready = 1'b1; enable = 1'b0; tick();
        rd_ready = 1'b0; retire = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (o_lvl[d] !== 32'd4) begin n_fail++; $display("FAIL fullpp_level dut%0d: got %0h, expected 4", d, o_lvl[d]); end
            n_checks++; if (o_drop[d] !== 32'd0) begin n_fail++; $display("FAIL fullpp_drop dut%0d: got %0h, expected 0", d, o_drop[d]); end
            n_checks++; if (o_ovf[d] !== 1'b0) begin n_fail++; $display("FAIL fullpp_overflow dut%0d: got %0h, expected 0", d, o_ovf[d]); end
            n_checks++; if (o_seq[d] !== 32'd1) begin n_fail++; $display("FAIL fullpp_head dut%0d: got %0h, expected 1", d, o_seq[d]); end
        end
    endtask

    task automatic test_halt();
        logic [31:0] pcs [5];
        pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h14; pcs[3] = 32'h14; pcs[4] = 32'h18;
        reset_dut();
        enable = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            drive_retire(pcs[i]); tick();
            for (int d = 0; d < 2; d++) begin
                if (i == 2) begin
                    n_checks++; if (o_halt[d] !== 1'b0) begin n_fail++; $display("FAIL halt_early dut%0d: got %0h, expected 0", d, o_halt[d]); end
                end
                if (i == 3) begin
                    n_checks++; if (o_halt[d] !== 1'b1) begin n_fail++; $display("FAIL halt_set dut%0d: got %0h, expected 1", d, o_halt[d]); end
                end
            end
        end
        retire = 1'b0; enable = 1'b0; tick();
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (o_lvl[d] !== 32'd4) begin n_fail++; $display("FAIL halt_level dut%0d: got %0h, expected 4", d, o_lvl[d]); end
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 2; d++) begin
                n_checks++; if (o_pc[d] !== pcs[k]) begin n_fail++; $display("FAIL halt_drain_pc dut%0d: got %0h, expected %0h", d, o_pc[d], pcs[k]); end
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (o_valid[d] !== 1'b0) begin n_fail++; $display("FAIL halt_no_0x18 dut%0d: got %0h, expected 0", d, o_valid[d]); end
            n_checks++; if (o_halt[d] !== 1'b1) begin n_fail++; $display("FAIL halt_sticky dut%0d: got %0h, expected 1", d, o_halt[d]); end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset_dut();
        enable = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            drive_retire(32'h20); tick();
        end
        retire = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (o_lvl[d] !== 32'd3) begin n_fail++; $display("FAIL mid_pre_level dut%0d: got %0h, expected 3", d, o_lvl[d]); end
        end
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (o_valid[d] !== 1'b0) begin n_fail++; $display("FAIL mid_valid dut%0d: got %0h, expected 0", d, o_valid[d]); end
            n_checks++; if (o_lvl[d] !== 32'd0) begin n_fail++; $display("FAIL mid_level dut%0d: got %0h, expected 0", d, o_lvl[d]); end
            n_checks++; if (o_halt[d] !== 1'b0) begin n_fail++; $display("FAIL mid_halted dut%0d: got %0h, expected 0", d, o_halt[d]); end
        end
        tick();
        reset = 1'b0;
        enable = 1'b1; tick();
        drive_retire(32'h80); tick();
        retire = 1'b0; enable = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (o_seq[d] !== 32'd0) begin n_fail++; $display("FAIL mid_seq_restart dut%0d: got %0h, expected 0", d, o_seq[d]); end
            n_checks++; if (o_pc[d] !== 32'h80) begin n_fail++; $display("FAIL mid_pc dut%0d: got %0h, expected 80", d, o_pc[d]); end
        end
    endtask

    task automatic test_random();
        rec_t        h;
        logic [31:0] last_pc;
        reset_dut();
        last_pc = '0;
        for (int c = 0; c < 2000; c++) begin
            enable   = ($urandom_range(15) != 0);
            rd_ready = ($urandom_range(2) == 0);
            if ($urandom_range(7) != 0) begin
                if ($urandom_range(2) != 0) last_pc = {$urandom_range(255), 2'b00};
                drive_retire(last_pc);
            end else begin
                retire = 1'b0;
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                n_checks++; if (o_valid[d] !== (qsize(d) > 0)) begin n_fail++; $display("FAIL rnd_valid dut%0d cyc%0d: got %0h, expected %0h", d, c, o_valid[d], qsize(d) > 0); end
                n_checks++; if (o_lvl[d] !== 32'(qsize(d))) begin n_fail++; $display("FAIL rnd_level dut%0d cyc%0d: got %0h, expected %0h", d, c, o_lvl[d], qsize(d)); end
                n_checks++; if (o_halt[d] !== mhalt[d]) begin n_fail++; $display("FAIL rnd_halted dut%0d cyc%0d: got %0h, expected %0h", d, c, o_halt[d], mhalt[d]); end
                n_checks++; if (o_ovf[d] !== movf[d]) begin n_fail++; $display("FAIL rnd_overflow dut%0d cyc%0d: got %0h, expected %0h", d, c, o_ovf[d], movf[d]); end
                n_checks++; if (o_drop[d] !== 32'(mdrop[d])) begin n_fail++; $display("FAIL rnd_drop dut%0d cyc%0d: got %0h, expected %0h", d, c, o_drop[d], mdrop[d]); end
                if (qsize(d) > 0) begin
                    h = qhead(d);
                    n_checks++;
                    if (o_seq[d] !== 32'(h.seq) || o_pc[d] !== h.pc || o_instr[d] !== h.instr ||
                        o_dma[d] !== h.dma || o_ra[d] !== h.ra || o_dwe[d] !== h.dwe) begin
                        n_fail++;
                        $display("FAIL rnd_head dut%0d cyc%0d: got seq %0h pc %0h instr %0h ra %0h dma %0h dwe %0h, expected seq %0h pc %0h instr %0h ra %0h dma %0h dwe %0h",
                                 d, c, o_seq[d], o_pc[d], o_instr[d], o_ra[d], o_dma[d], o_dwe[d],
                                 h.seq, h.pc, h.instr, h.ra, h.dma, h.dwe);
                    end
                end
            end
        end
        retire = 1'b0; enable = 1'b0; rd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop_push();
        test_halt();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
